// File: rtl/acsu_pipe_pkg.sv
// Shared Viterbi types and helpers: state counts, trellis predecessors,
// saturating metric adds.
package viterbi_pkg;

  localparam int MW = 32;

  typedef logic [MW-1:0] metric_t;

  function automatic int ns_of(input int k);
    return 1 << (k - 1);
  endfunction

  function automatic int sw_of(input int k);
    return (k > 1) ? k - 1 : 1;
  endfunction

  function automatic int pred0(input int j, input int ns);
    return 2 * (j % (ns / 2));
  endfunction

  function automatic metric_t sat_add(
    input metric_t a,
    input metric_t b,
    input int      w
  );
    logic [MW:0] s;
    metric_t     mx;
    s  = {1'b0, a} + {1'b0, b};
    mx = metric_t'((64'd1 << w) - 64'd1);
    return (s > {1'b0, mx}) ? mx : s[MW-1:0];
  endfunction

endpackage

// File: rtl/acsu_pipe_if.sv
// BMU -> ACSU -> TBU bundle: one trellis step in,
// one decision vector out.
interface acsu_pipe_if #(
  parameter int K    = 3,
  parameter int BM_W = 2,
  parameter int PM_W = 8
);
  import viterbi_pkg::*;

  localparam int NS = ns_of(K);
  localparam int SW = sw_of(K);

  logic                   valid_i;
  logic                   start_i;
  logic [2*NS*BM_W-1:0]   bm_i;
  logic [NS-1:0]          dec_o;
  logic                   dec_valid_o;
  logic [SW-1:0]          best_state_o;
  logic [NS*PM_W-1:0]     pm_o;

  modport master (
    output valid_i, start_i, bm_i,
    input  dec_o, dec_valid_o, best_state_o, pm_o
  );

  modport slave (
    input  valid_i, start_i, bm_i,
    output dec_o, dec_valid_o, best_state_o, pm_o
  );

endinterface

// File: rtl/acsu_pipe_acs_cell.sv
// One add-compare-select butterfly half: two saturating adds,
// compare, select. Ties pick branch 0.
module acs_cell
  import viterbi_pkg::*;
#(
  parameter int PM_W = 8,
  parameter int BM_W = 2
) (
  input  logic [PM_W-1:0] pm0,
  input  logic [PM_W-1:0] pm1,
  input  logic [BM_W-1:0] bm0,
  input  logic [BM_W-1:0] bm1,
  output logic [PM_W-1:0] pm_new,
  output logic            dec
);

  metric_t c0;
  metric_t c1;

  always_comb begin
    c0     = sat_add(metric_t'(pm0), metric_t'(bm0), PM_W);
    c1     = sat_add(metric_t'(pm1), metric_t'(bm1), PM_W);
    dec    = (c1 < c0);
    pm_new = PM_W'(dec ? c1 : c0);
  end

endmodule

// File: rtl/acsu_pipe.sv
// Registered radix-2 ACS unit: path metrics, start mux,
// renormaliser and best-state search.
module acsu_pipe
  import viterbi_pkg::*;
#(
  parameter int K         = 3,
  parameter int BM_W      = 2,
  parameter int PM_W      = 8,
  parameter int INIT_BIAS = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  acsu_pipe_if.slave  bus
);

  localparam int NS = ns_of(K);
  localparam int SW = sw_of(K);

  typedef logic [PM_W-1:0] pm_t;

  pm_t           pm_q [NS];
  pm_t           base [NS];
  pm_t           acs  [NS];
  pm_t           nxt  [NS];
  pm_t           mn;
  logic [NS-1:0] dec;
  logic [NS-1:0] dec_q;
  logic [SW-1:0] best;
  logic [SW-1:0] best_q;
  logic          dv_q;
  logic          all_msb;

  function automatic pm_t init_pm(input int j);
    return (j == 0) ? '0 : pm_t'(INIT_BIAS);
  endfunction

  // a start beat restarts the frame from the init vector
  always_comb begin
    for (int j = 0; j < NS; j++)
      base[j] = bus.start_i ? init_pm(j) : pm_q[j];
  end

  for (genvar j = 0; j < NS; j++) begin : g_acs
    localparam int P0 = pred0(j, NS);
    acs_cell #(
      .PM_W (PM_W),
      .BM_W (BM_W)
    ) u_cell (
      .pm0    (base[P0]),
      .pm1    (base[P0+1]),
      .bm0    (bus.bm_i[(2*j)*BM_W +: BM_W]),
      .bm1    (bus.bm_i[(2*j+1)*BM_W +: BM_W]),
      .pm_new (acs[j]),
      .dec    (dec[j])
    );
  end

  // all metrics in the upper half: drop the common MSB
  always_comb begin
    all_msb = 1'b1;
    for (int j = 0; j < NS; j++)
      all_msb = all_msb & acs[j][PM_W-1];
    for (int j = 0; j < NS; j++)
      nxt[j] = all_msb ? {1'b0, acs[j][PM_W-2:0]} : acs[j];
  end

  always_comb begin
    best = '0;
    mn   = nxt[0];
    for (int j = 1; j < NS; j++) begin
      if (nxt[j] < mn) begin
        mn   = nxt[j];
        best = SW'(j);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int j = 0; j < NS; j++)
        pm_q[j] <= init_pm(j);
      dec_q  <= '0;
      best_q <= '0;
      dv_q   <= 1'b0;
    end else begin
      dv_q <= bus.valid_i;
      if (bus.valid_i) begin
        for (int j = 0; j < NS; j++)
          pm_q[j] <= nxt[j];
        dec_q  <= dec;
        best_q <= best;
      end
    end
  end

  always_comb begin
    bus.pm_o = '0;
    for (int j = 0; j < NS; j++)
      bus.pm_o[j*PM_W +: PM_W] = pm_q[j];
  end

  assign bus.dec_o        = dec_q;
  assign bus.dec_valid_o  = dv_q;
  assign bus.best_state_o = best_q;

endmodule

// File: tb/tb_acsu_pipe.sv
// Bench for acsu_pipe: directed trellis cases plus a random stream,
// K=3 and K=5, against a behavioural metric model.
module tb_acsu_pipe;
  import viterbi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  acsu_pipe_if #(.K(3), .BM_W(2), .PM_W(8)) i3 ();
  acsu_pipe_if #(.K(3), .BM_W(2), .PM_W(8)) ib ();
  acsu_pipe_if #(.K(5), .BM_W(2), .PM_W(8)) i5 ();

  acsu_pipe #(.K(3), .BM_W(2), .PM_W(8), .INIT_BIAS(64)) u3 (
    .clk_i (clk), .rst_i (rst), .bus (i3)
  );
  acsu_pipe #(.K(3), .BM_W(2), .PM_W(8), .INIT_BIAS(254)) ub (
    .clk_i (clk), .rst_i (rst), .bus (ib)
  );
  acsu_pipe #(.K(5), .BM_W(2), .PM_W(8), .INIT_BIAS(64)) u5 (
    .clk_i (clk), .rst_i (rst), .bus (i5)
  );

  int n_chk  = 0;
  int n_fail = 0;

  int mns   [3] = '{4, 4, 16};
  int mbias [3] = '{64, 254, 64};
  int mpm   [3][16];
  int mdec  [3];
  int mbest [3];
  bit mdv   [3];

  bit v [3];
  bit s [3];
  int q [3][32];

  logic [31:0] pm_hold;
  logic [3:0]  dec_hold;

  task automatic chk(input string tag, input logic [127:0] a,
                     input logic [127:0] e);
    n_chk++;
    assert (a === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, a, e);
    end
  endtask

  task automatic model_step(input int u);
    int src [16];
    int p0, c0, c1, nw;
    bit all;
    if (rst) begin
      for (int j = 0; j < 16; j++) mpm[u][j] = (j == 0) ? 0 : mbias[u];
      mdec[u] = 0; mbest[u] = 0; mdv[u] = 0;
      return;
    end
    mdv[u] = v[u];
    if (!v[u]) return;
    for (int j = 0; j < 16; j++)
      src[j] = s[u] ? ((j == 0) ? 0 : mbias[u]) : mpm[u][j];
    all = 1; mdec[u] = 0;
    for (int j = 0; j < mns[u]; j++) begin
      p0 = 2 * (j % (mns[u] / 2));
      c0 = src[p0] + q[u][2*j];
      c1 = src[p0+1] + q[u][2*j+1];
      if (c0 > 255) c0 = 255;
      if (c1 > 255) c1 = 255;
      if (c1 < c0) begin nw = c1; mdec[u] |= (1 << j); end
      else nw = c0;
      mpm[u][j] = nw;
      if (nw < 128) all = 0;
    end
    if (all) for (int j = 0; j < mns[u]; j++) mpm[u][j] -= 128;
    mbest[u] = 0;
    for (int j = 1; j < mns[u]; j++)
      if (mpm[u][j] < mpm[u][mbest[u]]) mbest[u] = j;
  endtask

  task automatic check_all();
    logic [127:0] e, ap, ad, ab;
    logic adv;
    for (int u = 0; u < 3; u++) begin
      e = '0;
      for (int j = 0; j < mns[u]; j++) e[j*8 +: 8] = 8'(mpm[u][j]);
      case (u)
        0: begin ap = 128'(i3.pm_o); ad = 128'(i3.dec_o);
                 ab = 128'(i3.best_state_o); adv = i3.dec_valid_o; end
        1: begin ap = 128'(ib.pm_o); ad = 128'(ib.dec_o);
                 ab = 128'(ib.best_state_o); adv = ib.dec_valid_o; end
        default: begin ap = 128'(i5.pm_o); ad = 128'(i5.dec_o);
                 ab = 128'(i5.best_state_o); adv = i5.dec_valid_o; end
      endcase
      chk($sformatf("m%0d_pm", u), ap, e);
      chk($sformatf("m%0d_dec", u), ad, 128'(mdec[u]));
      chk($sformatf("m%0d_best", u), ab, 128'(mbest[u]));
      chk($sformatf("m%0d_dv", u), 128'(adv), 128'(mdv[u]));
    end
  endtask

  task automatic cycle();
    i3.valid_i = v[0]; i3.start_i = s[0];
    ib.valid_i = v[1]; ib.start_i = s[1];
    i5.valid_i = v[2]; i5.start_i = s[2];
    for (int k = 0; k < 8; k++) begin
      i3.bm_i[k*2 +: 2] = 2'(q[0][k]);
      ib.bm_i[k*2 +: 2] = 2'(q[1][k]);
    end
    for (int k = 0; k < 32; k++) i5.bm_i[k*2 +: 2] = 2'(q[2][k]);
    @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) model_step(u);
    check_all();
    for (int u = 0; u < 3; u++) begin v[u] = 0; s[u] = 0; end
  endtask

  task automatic fill(input int u, input int val);
    for (int k = 0; k < 32; k++) q[u][k] = val;
  endtask

  initial begin
    rst = 1'b1;
    for (int u = 0; u < 3; u++) begin v[u] = 0; s[u] = 0; fill(u, 0); end
    cycle();
    cycle();
    chk("rst_pm", 128'(i3.pm_o), 128'({8'd64, 8'd64, 8'd64, 8'd0}));
    chk("rst_dv", 128'(i3.dec_valid_o), 128'(0));
    rst = 1'b0;

    v[0] = 1; s[0] = 1; fill(0, 1);
    cycle();
    chk("t1_pm", 128'(i3.pm_o), 128'({8'd65, 8'd1, 8'd65, 8'd1}));
    chk("t1_dec", 128'(i3.dec_o), 128'(0));
    chk("t1_dv", 128'(i3.dec_valid_o), 128'(1));

    v[0] = 1; s[0] = 1; fill(0, 0);
    cycle();
    for (int i = 0; i < 42; i++) begin v[0] = 1; fill(0, 3); cycle(); end
    chk("t2_126", 128'(i3.pm_o), 128'({4{8'd126}}));
    v[0] = 1; fill(0, 3);
    cycle();
    chk("t2_norm", 128'(i3.pm_o), 128'({4{8'd1}}));

    for (int i = 0; i < 3; i++) begin v[0] = 1; fill(0, 3); cycle(); end
    chk("t3_ten", 128'(i3.pm_o), 128'({4{8'd10}}));
    v[0] = 1; fill(0, 0); q[0][0] = 2; q[0][1] = 2;
    cycle();
    chk("t3_tie", 128'(i3.dec_o[0]), 128'(0));
    v[0] = 1; fill(0, 0); q[0][0] = 3; q[0][1] = 0;
    cycle();
    chk("t3_win", 128'(i3.dec_o[0]), 128'(1));
    chk("t3_pm0", 128'(i3.pm_o[7:0]), 128'(10));

    v[1] = 1; s[1] = 1; fill(1, 3);
    cycle();
    chk("t4_sat", 128'(ib.pm_o), 128'({8'd255, 8'd3, 8'd255, 8'd3}));

    pm_hold  = i3.pm_o;
    dec_hold = i3.dec_o;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t5_pm", 128'(i3.pm_o), 128'(pm_hold));
      chk("t5_dec", 128'(i3.dec_o), 128'(dec_hold));
      chk("t5_dv", 128'(i3.dec_valid_o), 128'(0));
    end

    v[0] = 1; v[2] = 1;
    for (int k = 0; k < 32; k++) begin
      q[0][k] = int'($urandom_range(0, 3));
      q[2][k] = int'($urandom_range(0, 3));
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t6_rst", 128'(i3.pm_o), 128'({8'd64, 8'd64, 8'd64, 8'd0}));
    chk("t6_dv", 128'(i3.dec_valid_o), 128'(0));
    for (int i = 0; i < 5; i++) begin
      v[0] = 1; v[2] = 1; s[0] = (i == 3); s[2] = (i == 3);
      for (int k = 0; k < 32; k++) begin
        q[0][k] = int'($urandom_range(0, 3));
        q[2][k] = int'($urandom_range(0, 3));
      end
      cycle();
    end

    for (int i = 0; i < 10000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      v[0] = ($urandom_range(0, 4) != 0);
      v[2] = ($urandom_range(0, 4) != 0);
      s[0] = ($urandom_range(0, 19) == 0);
      s[2] = ($urandom_range(0, 19) == 0);
      for (int k = 0; k < 32; k++) begin
        q[0][k] = int'($urandom_range(0, 3));
        q[2][k] = int'($urandom_range(0, 3));
      end
      cycle();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
